// File: rtl/avalon_aes_host_sequencer.sv
// Avalon-MM master that loads the AES slave, polls DONE, reads the plaintext and returns it on a valid/ready port.
// Latency is 16 cycles from accept to RSP_VALID with immediate DONE; the request port is held off until the response handshake.
module avalon_aes_host_sequencer #(
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 4096,
    parameter int READ_WAIT = 0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         REQ_VALID,
    output logic         REQ_READY,
    input  logic [127:0] REQ_KEY,
    input  logic [127:0] REQ_MSG,
    output logic         RSP_VALID,
    input  logic         RSP_READY,
    output logic [127:0] RSP_DATA,
    output logic         RSP_TIMEOUT,
    output logic         AVL_READ,
    output logic         AVL_WRITE,
    output logic         AVL_CS,
    output logic [3:0]   AVL_BYTE_EN,
    output logic [3:0]   AVL_ADDR,
    output logic [31:0]  AVL_WRITEDATA,
    input  logic [31:0]  AVL_READDATA
);

    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam int WW = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(READ_WAIT);
    localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_KEY,
        S_WR_MSG,
        S_WR_START,
        S_POLL,
        S_GAP,
        S_RD_DEC,
        S_WR_CLR,
        S_RESP
    } state_t;

    state_t         state, state_n;
    logic [1:0]     idx, idx_n;
    logic [WW-1:0]  wcnt, wcnt_n;
    logic [GW-1:0]  gcnt, gcnt_n;
    logic [PW-1:0]  pcnt, pcnt_n;
    logic [127:0]   key_q, msg_q, data_q, data_n, key_src;
    logic           timeout_q, timeout_n;
    logic           rd_q, rd_n, wr_q, wr_n;
    logic [3:0]     addr_q, addr_n;
    logic [31:0]    wdata_q, wdata_n;
    logic           accept;

    assign REQ_READY     = (state == S_IDLE);
    assign accept        = REQ_VALID & REQ_READY;
    assign RSP_VALID     = (state == S_RESP);
    assign RSP_DATA      = data_q;
    assign RSP_TIMEOUT   = timeout_q;
    assign AVL_READ      = rd_q;
    assign AVL_WRITE     = wr_q;
    assign AVL_CS        = rd_q | wr_q;
    assign AVL_BYTE_EN   = 4'hF;
    assign AVL_ADDR      = addr_q;
    assign AVL_WRITEDATA = wdata_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            idx       <= '0;
            wcnt      <= '0;
            gcnt      <= '0;
            pcnt      <= '0;
            key_q     <= '0;
            msg_q     <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            wcnt      <= wcnt_n;
            gcnt      <= gcnt_n;
            pcnt      <= pcnt_n;
            data_q    <= data_n;
            timeout_q <= timeout_n;
            rd_q      <= rd_n;
            wr_q      <= wr_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            if (accept) begin
                key_q <= REQ_KEY;
                msg_q <= REQ_MSG;
            end
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        wcnt_n    = wcnt;
        gcnt_n    = gcnt;
        pcnt_n    = pcnt;
        data_n    = data_q;
        timeout_n = timeout_q;

        case (state)
            S_IDLE: begin
                if (REQ_VALID) begin
                    state_n   = S_WR_KEY;
                    idx_n     = 2'd0;
                    pcnt_n    = '0;
                    timeout_n = 1'b0;
                    data_n    = '0;
                end
            end
            S_WR_KEY: begin
                idx_n = idx + 2'd1;
                if (idx == 2'd3) state_n = S_WR_MSG;
            end
            S_WR_MSG: begin
                idx_n = idx + 2'd1;
                if (idx == 2'd3) state_n = S_WR_START;
            end
            S_WR_START: begin
                state_n = S_POLL;
                wcnt_n  = '0;
            end
            S_POLL: begin
                if (wcnt != WAIT_LAST) begin
                    wcnt_n = wcnt + WW'(1);
                end else if (AVL_READDATA[0]) begin
                    state_n = S_RD_DEC;
                    idx_n   = 2'd0;
                    wcnt_n  = '0;
                end else begin
                    if (pcnt != POLL_LIMIT) pcnt_n = pcnt + PW'(1);
                    wcnt_n = '0;
                    gcnt_n = '0;
                    if (pcnt_n == POLL_LIMIT) begin
                        timeout_n = 1'b1;
                        state_n   = S_WR_CLR;
                    end else if (POLL_GAP == 0) begin
                        state_n = S_POLL;
                    end else begin
                        state_n = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_n = S_POLL;
                    wcnt_n  = '0;
                end else begin
                    gcnt_n = gcnt + GW'(1);
                end
            end
            S_RD_DEC: begin
                if (wcnt != WAIT_LAST) begin
                    wcnt_n = wcnt + WW'(1);
                end else begin
                    data_n[{idx, 5'b0} +: 32] = AVL_READDATA;
                    idx_n  = idx + 2'd1;
                    wcnt_n = '0;
                    if (idx == 2'd3) state_n = S_WR_CLR;
                end
            end
            S_WR_CLR: state_n = S_RESP;
            S_RESP: begin
                if (RSP_READY) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Strobes are decoded from the next state so they appear registered, one cycle ahead of nothing.
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        addr_n  = 4'd0;
        wdata_n = 32'd0;
        key_src = (state == S_IDLE) ? REQ_KEY : key_q;
        case (state_n)
            S_WR_KEY: begin
                wr_n    = 1'b1;
                addr_n  = {2'b00, idx_n};
                wdata_n = key_src[{idx_n, 5'b0} +: 32];
            end
            S_WR_MSG: begin
                wr_n    = 1'b1;
                addr_n  = {2'b01, idx_n};
                wdata_n = msg_q[{idx_n, 5'b0} +: 32];
            end
            S_WR_START: begin
                wr_n    = 1'b1;
                addr_n  = 4'd14;
                wdata_n = 32'h8000_0000;
            end
            S_POLL: begin
                rd_n   = 1'b1;
                addr_n = 4'd15;
            end
            S_RD_DEC: begin
                rd_n   = 1'b1;
                addr_n = {2'b10, idx_n};
            end
            S_WR_CLR: begin
                wr_n   = 1'b1;
                addr_n = 4'd14;
            end
            default: ;
        endcase
    end

endmodule
